// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter: FSM state
// encoding, default data width and the wrap-around index helper used by the
// priority picker.
package axi_stream_pkg;

    // Arbiter FSM states: IDLE arbitrates, GRANT streams one packet.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Default TDATA width per stream.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Index reached by stepping 'off' positions upward from 'base' in a ring
    // of 'n' entries.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// by searching upward from the entry after 'last', wrapping around the ring.
// The entry 'last' itself is considered only after every other entry.
module rr_priority_pick
    import axi_stream_pkg::*;
#(
    parameter  int NUM_STREAMS = 2,
    localparam int SEL_WIDTH   = $clog2(NUM_STREAMS)
) (
    input  logic [NUM_STREAMS-1:0] req,
    input  logic [SEL_WIDTH-1:0]   last,
    output logic                   any,
    output logic [SEL_WIDTH-1:0]   idx
);

    logic [SEL_WIDTH-1:0] cand_s;

    // Walk the ring from last+1; the first hit wins and later hits are ignored.
    always_comb begin
        any    = 1'b0;
        idx    = {SEL_WIDTH{1'b0}};
        cand_s = {SEL_WIDTH{1'b0}};
        for (int off = 1; off <= NUM_STREAMS; off++) begin
            cand_s = SEL_WIDTH'(rr_wrap(int'(last), off, NUM_STREAMS));
            if (!any && req[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-level round-robin arbiter for NUM_STREAMS AXI-Stream sources sharing
// one sink. A grant is held from arbitration until the granted source's TLAST
// beat is accepted; granted beats pass through a single registered output
// stage. 'select' reports the current or most recent grant.
module axi_stream_rr_arbiter
    import axi_stream_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int NUM_STREAMS = 2,
    localparam int SEL_WIDTH   = $clog2(NUM_STREAMS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_STREAMS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_STREAMS-1:0]            s_tvalid,
    input  logic [NUM_STREAMS-1:0]            s_tlast,
    output logic [NUM_STREAMS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [SEL_WIDTH-1:0]              select,
    output logic                              busy
);

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [SEL_WIDTH-1:0]     select_r;
    logic [SEL_WIDTH-1:0]     last_grant_r;
    logic                     sel_load_s;

    logic                     pick_any_s;
    logic [SEL_WIDTH-1:0]     pick_idx_s;

    logic [DATA_WIDTH-1:0]    grant_data_s;
    logic                     grant_valid_s;
    logic                     grant_last_s;
    logic                     out_free_s;
    logic                     accept_s;
    logic [NUM_STREAMS-1:0]   s_tready_s;

    logic [DATA_WIDTH-1:0]    m_tdata_r;
    logic                     m_tvalid_r;
    logic                     m_tlast_r;

    rr_priority_pick #(
        .NUM_STREAMS (NUM_STREAMS)
    ) u_pick (
        .req  (s_tvalid),
        .last (last_grant_r),
        .any  (pick_any_s),
        .idx  (pick_idx_s)
    );

    // Route the currently selected source's data, valid and last.
    always_comb begin
        grant_data_s  = {DATA_WIDTH{1'b0}};
        grant_valid_s = 1'b0;
        grant_last_s  = 1'b0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (select_r == SEL_WIDTH'(i)) begin
                grant_data_s  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                grant_valid_s = s_tvalid[i];
                grant_last_s  = s_tlast[i];
            end else begin
                grant_data_s  = grant_data_s;
                grant_valid_s = grant_valid_s;
                grant_last_s  = grant_last_s;
            end
        end
    end

    // The output stage can take a beat when empty or draining this cycle;
    // this keeps full throughput and makes s_tready combinational in m_tready.
    assign out_free_s = !m_tvalid_r || m_tready;

    // FSM next state, per-source ready and source-beat acceptance.
    always_comb begin
        state_nxt_s = state_r;
        s_tready_s  = {NUM_STREAMS{1'b0}};
        accept_s    = 1'b0;
        sel_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    sel_load_s  = 1'b1;
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                s_tready_s[select_r] = out_free_s;
                accept_s             = grant_valid_s && out_free_s;
                // A gap from the granted source keeps the grant; only its
                // TLAST beat releases it.
                if (accept_s && grant_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, select and last-grant registers; reset leaves stream 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            select_r     <= {SEL_WIDTH{1'b0}};
            last_grant_r <= SEL_WIDTH'(NUM_STREAMS - 1);
        end else begin
            state_r <= state_nxt_s;
            if (sel_load_s) begin
                select_r     <= pick_idx_s;
                last_grant_r <= pick_idx_s;
            end else begin
                select_r     <= select_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Output register: a new load wins over a drain so valid stays high;
    // with neither, contents hold (stable under backpressure).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata_r  <= {DATA_WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                m_tdata_r  <= grant_data_s;
                m_tvalid_r <= 1'b1;
                m_tlast_r  <= grant_last_s;
            end else if (m_tvalid_r && m_tready) begin
                m_tdata_r  <= m_tdata_r;
                m_tvalid_r <= 1'b0;
                m_tlast_r  <= 1'b0;
            end else begin
                m_tdata_r  <= m_tdata_r;
                m_tvalid_r <= m_tvalid_r;
                m_tlast_r  <= m_tlast_r;
            end
        end
    end

    assign s_tready = s_tready_s;
    assign m_tdata  = m_tdata_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tlast  = m_tlast_r;
    assign select   = select_r;
    assign busy     = (state_r == ST_GRANT);

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Self-checking bench for axi_stream_rr_arbiter: directed scenarios plus a
// randomized run, all checked against a packet-level reference model
// (round-robin rule, one-deep output scoreboard, expected ready vector).
module tb_axi_stream_rr_arbiter;

    localparam int DW = 8;
    localparam int NS = 2;
    localparam int SW = 1;
    localparam logic [NS-1:0] ONE = {{(NS-1){1'b0}}, 1'b1};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [SW-1:0]     select;
    logic              busy;

    always #5 clk = ~clk;

    axi_stream_rr_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_STREAMS (NS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .select   (select),
        .busy     (busy)
    );

    typedef struct packed {
        logic [3:0]    gap;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } obeat_t;

    beat_t        src_q [NS][$];
    int           wait_cnt [NS];
    logic [NS-1:0] acc_prev;
    obeat_t       sb [$];
    int           out_log [$];
    int           out_last_log [$];
    int           grant_log [$];
    bit           mdl_idle;
    int           mdl_last;
    int           mdl_sel;
    bit           prev_busy;
    bit           rand_gap;
    bit           rand_ready;
    logic         mready_val;
    int           checks;
    int           errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NS-1:0] req);
        for (int o = 1; o <= NS; o++) begin
            if (((req >> ((last + o) % NS)) & ONE) != '0) return (last + o) % NS;
        end
        return 0;
    endfunction

    function automatic logic [DW-1:0] lane(input logic [NS*DW-1:0] v, input int i);
        return DW'(v >> (i * DW));
    endfunction

    function automatic logic [NS*DW-1:0] set_lane(input logic [NS*DW-1:0] v, input int i,
                                                  input logic [DW-1:0] d);
        logic [NS*DW-1:0] m;
        m = (NS*DW)'({DW{1'b1}}) << (i * DW);
        return (v & ~m) | ((NS*DW)'(d) << (i * DW));
    endfunction

    task automatic add_beat(input int s, input logic [DW-1:0] d, input logic l, input int g);
        beat_t b;
        b.gap  = 4'(g);
        b.last = l;
        b.data = d;
        src_q[s].push_back(b);
    endtask

    // Source and sink driving, done at the falling edge.
    task automatic drive();
        logic [NS-1:0] bm;
        for (int i = 0; i < NS; i++) begin
            bm = ONE << i;
            if ((acc_prev & bm) != '0) begin
                void'(src_q[i].pop_front());
                wait_cnt[i] = 0;
                s_tvalid = s_tvalid & ~bm;
                s_tlast  = s_tlast & ~bm;
            end
            if ((s_tvalid & bm) == '0 && src_q[i].size() > 0) begin
                if (wait_cnt[i] < int'(src_q[i][0].gap)) begin
                    wait_cnt[i]++;
                end else if (!rand_gap || $urandom_range(0, 3) != 0) begin
                    s_tvalid = s_tvalid | bm;
                    if (src_q[i][0].last) s_tlast = s_tlast | bm;
                    else s_tlast = s_tlast & ~bm;
                    s_tdata = set_lane(s_tdata, i, src_q[i][0].data);
                end
            end
        end
        m_tready = rand_ready ? ($urandom_range(0, 2) != 0) : mready_val;
    endtask

    // Compare DUT against the model, then advance the model across one edge.
    task automatic sample_and_model();
        logic [NS-1:0] exp_ready;
        bit            nxt_idle;
        int            nxt_sel;
        bit            granted;
        obeat_t        ob;
        #1;
        chk("m_tvalid", 32'(m_tvalid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("m_tdata", 32'(m_tdata), 32'(sb[0].data));
            chk("m_tlast", 32'(m_tlast), 32'(sb[0].last));
        end
        chk("busy", 32'(busy), 32'(!mdl_idle));
        chk("select", 32'(select), 32'(mdl_sel));
        exp_ready = '0;
        if (!mdl_idle && (sb.size() == 0 || m_tready)) exp_ready = ONE << mdl_sel;
        chk("s_tready", 32'(s_tready), 32'(exp_ready));

        if (busy && !prev_busy) grant_log.push_back(int'(select));
        prev_busy = busy;
        if (m_tvalid && m_tready) begin
            out_log.push_back(int'(m_tdata));
            out_last_log.push_back(int'(m_tlast));
        end
        acc_prev = s_tvalid & s_tready;

        if (sb.size() != 0 && m_tready) void'(sb.pop_front());
        nxt_idle = mdl_idle;
        nxt_sel  = mdl_sel;
        granted  = 1'b0;
        if (mdl_idle) begin
            if (s_tvalid != '0) begin
                nxt_sel  = rr_pick(mdl_last, s_tvalid);
                nxt_idle = 1'b0;
                granted  = 1'b1;
            end
        end else if ((s_tvalid & exp_ready) != '0) begin
            ob.data = lane(s_tdata, mdl_sel);
            ob.last = ((s_tlast >> mdl_sel) & ONE) != '0;
            sb.push_back(ob);
            if (ob.last) nxt_idle = 1'b1;
        end
        @(posedge clk);
        mdl_idle = nxt_idle;
        mdl_sel  = nxt_sel;
        if (granted) mdl_last = nxt_sel;
    endtask

    task automatic cycle();
        drive();
        sample_and_model();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0) || !mdl_idle || (s_tvalid != '0);
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(pending()), 32'(0));
    endtask

    // Asynchronous reset from a falling-edge call point; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'(0));
        chk("rst_m_tlast", 32'(m_tlast), 32'(0));
        chk("rst_m_tdata", 32'(m_tdata), 32'(0));
        chk("rst_s_tready", 32'(s_tready), 32'(0));
        chk("rst_select", 32'(select), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            wait_cnt[i] = 0;
        end
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        acc_prev  = '0;
        sb.delete();
        out_log.delete();
        out_last_log.delete();
        grant_log.delete();
        mdl_idle  = 1'b1;
        mdl_last  = NS - 1;
        mdl_sel   = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string tag, input int q[$], input int e[$]);
        chk({tag, "_len"}, 32'(q.size()), 32'(e.size()));
        for (int k = 0; k < e.size() && k < q.size(); k++) chk(tag, 32'(q[k]), 32'(e[k]));
    endtask

    initial begin
        int total;
        int len;
        int s;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b1;
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        m_tready   = 1'b1;
        mready_val = 1'b1;
        rand_gap   = 1'b0;
        rand_ready = 1'b0;
        acc_prev   = '0;
        @(negedge clk);
        do_reset();
        cycles(3);

        // Single source, three beats.
        add_beat(0, 8'h11, 1'b0, 0);
        add_beat(0, 8'h22, 1'b0, 0);
        add_beat(0, 8'h33, 1'b1, 0);
        run_until_done("t1_done", 50);
        chk_log("t1_data", out_log, '{32'h11, 32'h22, 32'h33});
        chk_log("t1_last", out_last_log, '{0, 0, 1});
        chk_log("t1_grant", grant_log, '{0});

        // Contention straight after reset.
        do_reset();
        add_beat(0, 8'hA0, 1'b0, 0);
        add_beat(0, 8'hA1, 1'b1, 0);
        add_beat(1, 8'hB0, 1'b0, 0);
        add_beat(1, 8'hB1, 1'b1, 0);
        run_until_done("t2_done", 50);
        chk_log("t2_data", out_log, '{32'hA0, 32'hA1, 32'hB0, 32'hB1});
        chk_log("t2_grant", grant_log, '{0, 1});

        // Round-robin with continuous one-beat packets.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_beat(0, 8'(8'h30 + k), 1'b1, 0);
            add_beat(1, 8'(8'h40 + k), 1'b1, 0);
        end
        run_until_done("t3_done", 100);
        chk_log("t3_grant", grant_log, '{0, 1, 0, 1, 0, 1, 0, 1});
        chk_log("t3_data", out_log, '{32'h30, 32'h40, 32'h31, 32'h41, 32'h32, 32'h42, 32'h33, 32'h43});

        // Backpressure on a stream-1 packet.
        out_log.delete();
        grant_log.delete();
        mready_val = 1'b0;
        add_beat(1, 8'h51, 1'b0, 0);
        add_beat(1, 8'h52, 1'b0, 0);
        add_beat(1, 8'h53, 1'b1, 0);
        cycles(6);
        #1;
        chk("t4_hold_valid", 32'(m_tvalid), 32'(1));
        chk("t4_hold_data", 32'(m_tdata), 32'h51);
        chk("t4_hold_ready", 32'(s_tready), 32'(0));
        #4;
        mready_val = 1'b1;
        @(negedge clk);
        run_until_done("t4_done", 50);
        chk_log("t4_data", out_log, '{32'h51, 32'h52, 32'h53});
        chk_log("t4_grant", grant_log, '{1});

        // Mid-packet gap on stream 0 while stream 1 waits.
        out_log.delete();
        grant_log.delete();
        add_beat(0, 8'h61, 1'b0, 0);
        add_beat(0, 8'h62, 1'b0, 3);
        add_beat(0, 8'h63, 1'b0, 0);
        add_beat(0, 8'h64, 1'b1, 0);
        add_beat(1, 8'h71, 1'b0, 0);
        add_beat(1, 8'h72, 1'b1, 0);
        run_until_done("t5_done", 60);
        chk_log("t5_data", out_log, '{32'h61, 32'h62, 32'h63, 32'h64, 32'h71, 32'h72});
        chk_log("t5_grant", grant_log, '{0, 1});

        // Reset during beat 2 of a 4-beat packet.
        do_reset();
        add_beat(0, 8'h81, 1'b0, 0);
        add_beat(0, 8'h82, 1'b0, 0);
        add_beat(0, 8'h83, 1'b0, 0);
        add_beat(0, 8'h84, 1'b1, 0);
        cycles(3);
        #1;
        chk("t6_pre_valid", 32'(m_tvalid), 32'(1));
        chk("t6_pre_data", 32'(m_tdata), 32'h82);
        @(negedge clk);
        do_reset();
        add_beat(1, 8'h91, 1'b0, 0);
        add_beat(1, 8'h92, 1'b1, 0);
        run_until_done("t6_done", 50);
        chk_log("t6_data", out_log, '{32'h91, 32'h92});
        chk_log("t6_grant", grant_log, '{1});

        // Randomized traffic with random gaps and backpressure.
        out_log.delete();
        grant_log.delete();
        rand_gap   = 1'b1;
        rand_ready = 1'b1;
        total      = 0;
        for (int p = 0; p < 300; p++) begin
            s   = int'($urandom_range(0, NS - 1));
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
                add_beat(s, 8'($urandom), (b == len - 1), (b == 0) ? 0 : int'($urandom_range(0, 2)));
                total++;
            end
        end
        run_until_done("t7_done", 20000);
        chk("t7_count", 32'(out_log.size()), 32'(total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_rr_arbiter.md
Name: axi_stream_rr_arbiter

Overview:
Packet-level round-robin arbiter and mux controller for NUM_STREAMS AXI-Stream sources sharing one AXI-Stream sink.
- Grants one source at a time and holds the grant until that source's TLAST beat is accepted.
- Routes the granted source's data through one registered output stage.
- Drives the select code consumed by the downstream stream mux and debug logic.

Parameters:
- DATA_WIDTH, 8, TDATA width per stream.
- NUM_STREAMS, 2, number of source streams; legal range 2..16.
- SEL_WIDTH, $clog2(NUM_STREAMS), localparam; width of select/grant index.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  NUM_STREAMS*DATA_WIDTH  source data, flattened; stream i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_STREAMS  per-source TValid.
- s_tlast  in  NUM_STREAMS  per-source end-of-packet.
- s_tready  out  NUM_STREAMS  per-source TReady.
- m_tdata  out  DATA_WIDTH  sink data (registered).
- m_tvalid  out  1  sink TValid (registered).
- m_tlast  out  1  sink TLast (registered).
- m_tready  in  1  sink TReady.
- select  out  SEL_WIDTH  index of the current or most recent grant.
- busy  out  1  high while in state GRANT.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream) forces all outputs and state to the following values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, select=0, busy=0.
  - state=IDLE, last_grant=NUM_STREAMS-1, so stream 0 has first priority.
- Beat transfer: a source beat transfers when s_tvalid[i]&&s_tready[i]; a sink beat transfers when m_tvalid&&m_tready. Standard AXI-Stream rules apply.
- State IDLE:
  - s_tready is all zero.
  - If any s_tvalid is set, choose the first set bit searching upward from (last_grant+1) mod NUM_STREAMS with wrap-around.
  - Register the choice into select and last_grant, then go to GRANT on the next edge.
  - If no s_tvalid is set, stay in IDLE; select holds its previous value.
- State GRANT:
  - s_tready[select] = (!m_tvalid || m_tready); all other s_tready bits are 0. This path is combinational from m_tready.
  - On an accepted source beat, load m_tdata/m_tlast from stream select and set m_tvalid=1 on the next edge.
  - If m_tvalid&&m_tready and no new beat is loaded, clear m_tvalid.
  - When the accepted source beat has s_tlast=1, go to IDLE on the same edge. That beat still propagates to the output.
  - If the granted source drops s_tvalid mid-packet, the grant is kept (no re-arbitration mid-packet) and the state stays GRANT.
- Latency:
  - Source beat to m_tvalid: 1 cycle.
  - Packet end to next grant: 1 arbitration cycle in IDLE.
  - Full throughput (1 beat/clk) within a packet while m_tready=1.
- Output register under backpressure: m_tdata/m_tvalid/m_tlast are stable while m_tvalid=1 and m_tready=0.
- Fairness: after stream k's packet, stream k has lowest priority. Any continuously requesting stream is granted within NUM_STREAMS-1 packets.
- Simultaneous events:
  - A TLAST beat accepted and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - Output drain and new load in the same cycle: the load wins and m_tvalid stays 1.
- Zero-length packets do not exist; a single beat with tlast=1 is a one-beat packet.
- Reset mid-packet: the packet is truncated, nothing further is emitted, no TLAST is generated, and the arbiter returns to the stream-0 priority state.
- Out-of-range select values cannot occur; the select register only loads valid indices.

Decomposition:
- Shared package axi_stream_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Default DATA_WIDTH constant.
- One sub-module: rr_priority_pick.
  - Purely combinational.
  - Inputs: req[NUM_STREAMS], last[SEL_WIDTH].
  - Outputs: any, idx[SEL_WIDTH].
- FSM and output register remain in the top.

Test Plan:
- Single source: stream 0 sends 3 beats 0x11,0x22,0x33(tlast), m_tready=1.
  - Arbitration: select=0, busy rises one cycle after the first s_tvalid.
  - Output: m_tdata 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after acceptance; m_tlast only on 0x33.
- Contention after reset: both streams assert 2-beat packets simultaneously.
  - Stream 0 is granted first, stream 1 after one IDLE cycle.
  - Output order: A0,A1(tlast),B0,B1(tlast).
- Round-robin: both streams request continuously with 1-beat packets.
  - select alternates 0,1,0,1 over 4 packets; no stream is granted twice in a row.
- Backpressure: hold m_tready=0 for 4 cycles during a packet from stream 1.
  - s_tready[1]=0 after the first beat is held.
  - m_tdata and m_tvalid are stable; no beat is lost or duplicated when m_tready returns to 1.
- Mid-packet gap: granted stream 0 drops s_tvalid for 3 cycles while stream 1 requests.
  - select stays 0 and s_tready[1]=0 throughout.
  - Stream 1 is granted only after stream 0's tlast.
- Reset mid-packet: pull rst_n low during beat 2 of a 4-beat packet.
  - All outputs immediately go to 0.
  - After release, a new request from stream 1 alone is granted (select=1) and its packet is output intact.
